// File: rtl/fifo_drain_control.sv
// Read-side controller for the per-column weight FIFOs feeding the systolic array.
// Drains one tile per start request in flat or diagonally skewed order, with stall and empty gating.
module fifo_drain_control #(
    parameter int fifo_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  stagger_load,
    input  logic                  stall,
    input  logic [fifo_width-1:0] fifo_empty,
    output logic [fifo_width-1:0] fifo_rd_en,
    output logic [fifo_width-1:0] data_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  done_pulse
);

    localparam int COUNT_WIDTH = $clog2(2 * fifo_width);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [COUNT_WIDTH-1:0] FLAT_LAST    = COUNT_WIDTH'(fifo_width - 1);
    localparam logic [COUNT_WIDTH-1:0] STAGGER_LAST = COUNT_WIDTH'(2 * fifo_width - 2);

    logic [0:0]             started;
    logic [COUNT_WIDTH-1:0] count;
    logic                   stagger_latch;

    logic [fifo_width-1:0]  window;
    logic [COUNT_WIDTH-1:0] last;
    logic                   at_last;
    logic                   blocked;
    logic                   advance;
    logic [COUNT_WIDTH:0]   count_ext;

    assign count_ext = {1'b0, count};

    // Column i is in its read window for fifo_width consecutive steps, skewed by i when staggered.
    for (genvar i = 0; i < fifo_width; i++) begin : g_window
        localparam logic [COUNT_WIDTH:0] LO = (COUNT_WIDTH + 1)'(i);
        localparam logic [COUNT_WIDTH:0] HI = (COUNT_WIDTH + 1)'(i + fifo_width - 1);
        if (i == 0) begin : g_first
            assign window[i] = stagger_latch ? (count_ext <= HI) : (count <= FLAT_LAST);
        end else begin : g_rest
            assign window[i] = stagger_latch ? ((count_ext >= LO) && (count_ext <= HI))
                                             : (count <= FLAT_LAST);
        end
    end

    assign last    = stagger_latch ? STAGGER_LAST : FLAT_LAST;
    assign at_last = (count == last);

    // A single empty FIFO inside the window freezes every column so the diagonal skew survives.
    assign blocked    = |(window & fifo_empty);
    assign advance    = (started == DRAIN) & ~stall & ~blocked & ~reset;
    assign fifo_rd_en = advance ? window : '0;

    assign busy = (started == DRAIN);
    assign done = ~busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            started       <= IDLE;
            count         <= '0;
            stagger_latch <= 1'b0;
            done_pulse    <= 1'b0;
            data_valid    <= '0;
        end else begin
            data_valid <= fifo_rd_en;
            done_pulse <= advance & at_last;
            if (started == IDLE) begin
                if (active) begin
                    started       <= DRAIN;
                    count         <= '0;
                    stagger_latch <= stagger_load;
                end
            end else if (advance) begin
                if (at_last) begin
                    started <= IDLE;
                    count   <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_control.sv
// Self-checking bench for fifo_drain_control: cycle model plus a data_valid scoreboard queue,
// with scenario-level checks of read patterns, completion timing and per-column read totals.
module tb_fifo_drain_control;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         active = 1'b0;
    logic         stagger_load = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] fifo_empty = '0;
    logic [W-1:0] fifo_rd_en;
    logic [W-1:0] data_valid;
    logic         busy;
    logic         done;
    logic         done_pulse;

    fifo_drain_control #(.fifo_width(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .active       (active),
        .stagger_load (stagger_load),
        .stall        (stall),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .data_valid   (data_valid),
        .busy         (busy),
        .done         (done),
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    bit mStarted   = 1'b0;
    int mCount     = 0;
    bit mStag      = 1'b0;
    bit mDonePulse = 1'b0;
    logic [W-1:0] dvQueue[$];

    // Per-scenario recordings
    logic [W-1:0] trace[0:127];
    logic         busyTrace[0:127];
    logic [W-1:0] dvTrace[0:127];
    int           pulseAt[$];
    int           colReads[W];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] modelWindow();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (mStag) w[i] = (mCount >= i) && (mCount < i + W);
            else       w[i] = (mCount < W);
        end
        return w;
    endfunction

    // Drive one cycle at the falling edge, compare against the model, then step the model.
    task automatic applyStimulus(input logic rst, input logic act, input logic sl,
                                 input logic st, input logic [W-1:0] emp, input int k);
        logic [W-1:0] win;
        logic [W-1:0] expRd;
        logic         adv;
        int           lastStep;
        @(negedge clk);
        reset        = rst;
        active       = act;
        stagger_load = sl;
        stall        = st;
        fifo_empty   = emp;
        #2;
        win      = mStarted ? modelWindow() : '0;
        adv      = mStarted && !st && ((win & emp) == '0) && !rst;
        expRd    = adv ? win : '0;
        lastStep = mStag ? 2 * W - 2 : W - 1;

        checkOutput("rd_en", fifo_rd_en, expRd);
        checkOutput("busy", busy, mStarted);
        checkOutput("done", done, !mStarted);
        checkOutput("done_pulse", done_pulse, mDonePulse);
        if (dvQueue.size() > 0) checkOutput("data_valid", data_valid, dvQueue.pop_front());
        dvQueue.push_back(expRd);

        if (k >= 0 && k < 128) begin
            trace[k]     = fifo_rd_en;
            busyTrace[k] = busy;
            dvTrace[k]   = data_valid;
            if (done_pulse === 1'b1) pulseAt.push_back(k);
        end
        for (int i = 0; i < W; i++) if (fifo_rd_en[i] === 1'b1) colReads[i]++;

        if (rst) begin
            mStarted   = 1'b0;
            mCount     = 0;
            mStag      = 1'b0;
            mDonePulse = 1'b0;
        end else begin
            mDonePulse = adv && (mCount == lastStep);
            if (!mStarted && act) begin
                mStarted = 1'b1;
                mCount   = 0;
                mStag    = sl;
            end else if (adv) begin
                if (mCount == lastStep) begin
                    mStarted = 1'b0;
                    mCount   = 0;
                end else begin
                    mCount++;
                end
            end
        end
    endtask

    // Scenario-driven stimulus; stops after the wanted number of done pulses or the cycle budget.
    task automatic runScenario(input int scen, input int maxCycles, input int pulsesWanted);
        logic         rst, act, sl, st;
        logic [W-1:0] emp;
        int           k;
        pulseAt.delete();
        for (int i = 0; i < W; i++) colReads[i] = 0;
        for (int i = 0; i < 128; i++) begin
            trace[i]     = 'x;
            busyTrace[i] = 1'bx;
            dvTrace[i]   = 'x;
        end
        k = 0;
        while (k < maxCycles && (pulsesWanted == 0 || pulseAt.size() < pulsesWanted)) begin
            rst = 1'b0;
            act = (k == 0);
            sl  = 1'b0;
            st  = 1'b0;
            emp = '0;
            case (scen)
                1: sl = 1'b1;
                2: begin
                    st = (k >= 5 && k <= 7);
                    if (k == 10) emp[3] = 1'b1;
                end
                3: begin
                    sl = 1'b1;
                    if (k == 3) emp[15] = 1'b1;
                    if (k >= 4 && k <= 6) emp[1] = 1'b1;
                end
                4: begin
                    sl  = 1'b1;
                    rst = (k == 8);
                end
                5: begin
                    act = (pulseAt.size() == 0);
                    sl  = (k == 0) ? 1'b1 : k[0];
                end
                default: ;
            endcase
            applyStimulus(rst, act, sl, st, emp, k);
            k++;
        end
        checkOutput($sformatf("s%0d_pulses_seen", scen), pulseAt.size(), pulsesWanted);
    endtask

    task automatic checkColumnReads(input string tag, input int want);
        for (int i = 0; i < W; i++) checkOutput($sformatf("%s_col%0d", tag, i), colReads[i], want);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, -1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b1);
        checkOutput("reset_rd_en", fifo_rd_en, 16'h0000);
        checkOutput("reset_data_valid", data_valid, 16'h0000);
        idleCycles(2);

        $display("[TB] flat drain");
        runScenario(0, 60, 1);
        if (pulseAt.size() > 0) checkOutput("flat_pulse_cycle", pulseAt[0], 17);
        for (int k = 1; k <= 16; k++) checkOutput($sformatf("flat_rd_k%0d", k), trace[k], 16'hFFFF);
        checkOutput("flat_dv_k2", dvTrace[2], 16'hFFFF);
        checkOutput("flat_dv_k17", dvTrace[17], 16'hFFFF);
        checkColumnReads("flat", 16);
        idleCycles(2);
        checkOutput("flat_busy_after", busy, 1'b0);

        $display("[TB] staggered drain");
        runScenario(1, 80, 1);
        if (pulseAt.size() > 0) checkOutput("stag_pulse_cycle", pulseAt[0], 32);
        checkOutput("stag_count0", trace[1], 16'h0001);
        checkOutput("stag_count1", trace[2], 16'h0003);
        checkOutput("stag_count15", trace[16], 16'hFFFF);
        checkOutput("stag_count16", trace[17], 16'hFFFE);
        checkOutput("stag_count30", trace[31], 16'h8000);
        checkColumnReads("stag", 16);
        idleCycles(2);

        $display("[TB] back-pressure");
        runScenario(2, 80, 1);
        if (pulseAt.size() > 0) checkOutput("bp_pulse_cycle", pulseAt[0], 21);
        checkOutput("bp_stall_k5", trace[5], 16'h0000);
        checkOutput("bp_stall_k6", trace[6], 16'h0000);
        checkOutput("bp_stall_k7", trace[7], 16'h0000);
        checkOutput("bp_empty_k10", trace[10], 16'h0000);
        checkOutput("bp_resume_k11", trace[11], 16'hFFFF);
        checkColumnReads("bp", 16);
        idleCycles(2);

        $display("[TB] empty gating in stagger mode");
        runScenario(3, 80, 1);
        if (pulseAt.size() > 0) checkOutput("gate_pulse_cycle", pulseAt[0], 35);
        checkOutput("gate_out_of_window", trace[3], 16'h0007);
        checkOutput("gate_in_window_k4", trace[4], 16'h0000);
        checkOutput("gate_in_window_k6", trace[6], 16'h0000);
        checkOutput("gate_cleared", trace[7], 16'h000F);
        checkColumnReads("gate", 16);
        idleCycles(2);

        $display("[TB] reset mid-drain");
        runScenario(4, 20, 0);
        checkOutput("rst_busy_before", busyTrace[7], 1'b1);
        checkOutput("rst_rd_en_same_cycle", trace[8], 16'h0000);
        checkOutput("rst_busy_after", busyTrace[9], 1'b0);
        checkOutput("rst_dv_after", dvTrace[9], 16'h0000);
        runScenario(0, 60, 1);
        if (pulseAt.size() > 0) checkOutput("rst_fresh_pulse_cycle", pulseAt[0], 17);
        checkOutput("rst_fresh_flat_k1", trace[1], 16'hFFFF);
        idleCycles(2);

        $display("[TB] re-trigger with active held");
        runScenario(5, 100, 2);
        if (pulseAt.size() > 1) begin
            checkOutput("retrig_pulse0", pulseAt[0], 32);
            checkOutput("retrig_pulse1", pulseAt[1], 49);
        end
        checkOutput("retrig_count0", trace[1], 16'h0001);
        checkOutput("retrig_count15", trace[16], 16'hFFFF);
        checkOutput("retrig_count30", trace[31], 16'h8000);
        checkOutput("retrig_gap", trace[32], 16'h0000);
        checkOutput("retrig_second_flat", trace[33], 16'hFFFF);
        checkColumnReads("retrig", 32);
        idleCycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
